// File: rtl/atmega_tim4_hs.sv
// High-speed 10-bit Timer/Counter4 with fast PWM on OC4A and overflow/compare interrupt flags.
// Optional dead-time generator on oc4a/oc4a_n is built when ATMEGA_TIM4_DEAD_TIME_EN is defined.
module atmega_tim4_hs #(
  parameter string PLATFORM = "XILINX",
  parameter int BUS_ADDR_DATA_LEN = 6,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCCR4A_ADDR = 'h20,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCCR4B_ADDR = 'h21,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TC4H_ADDR   = 'h22,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TCNT4_ADDR  = 'h23,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] OCR4A_ADDR  = 'h24,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] OCR4C_ADDR  = 'h25,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIMSK4_ADDR = 'h26,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] TIFR4_ADDR  = 'h27,
  parameter logic [BUS_ADDR_DATA_LEN-1:0] DT4_ADDR    = 'h28
) (
  input  logic                         rst,
  input  logic                         clk,
  input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
  input  logic                         wr,
  input  logic                         rd,
  input  logic [7:0]                   bus_in,
  output logic [7:0]                   bus_out,
  input  logic                         tim_ck_en,
  input  logic                         tov_int_rst,
  input  logic                         oca_int_rst,
  output logic                         tov_int,
  output logic                         oca_int,
  output logic                         oc4a,
  output logic                         oc4a_n
);

  logic        pwm4a;
  logic [3:0]  cs4;
  logic [1:0]  tc4h;
  logic [9:0]  tcnt4;
  logic [9:0]  ocr4a_buf, ocr4a_act;
  logic [9:0]  ocr4c_buf, ocr4c_act;
  logic        toie4, ocie4a;
  logic        tov4, ocf4a;
  logic [13:0] prescaler;
  logic        oc4a_pwm;
  logic [7:0]  dt4_rd;

  logic        wr_tccr4a, wr_tccr4b, wr_tc4h, wr_tcnt, wr_ocra, wr_ocrc;
  logic        wr_timsk, wr_tifr, rd_tcnt;
  logic        clr_strobe, stopped;
  logic [13:0] ps_mask;
  logic        tick, tick_eff, at_top, wrap, match;
  logic [9:0]  wdata10;

  assign wr_tccr4a = wr && (addr == TCCR4A_ADDR);
  assign wr_tccr4b = wr && (addr == TCCR4B_ADDR);
  assign wr_tc4h   = wr && (addr == TC4H_ADDR);
  assign wr_tcnt   = wr && (addr == TCNT4_ADDR);
  assign wr_ocra   = wr && (addr == OCR4A_ADDR);
  assign wr_ocrc   = wr && (addr == OCR4C_ADDR);
  assign wr_timsk  = wr && (addr == TIMSK4_ADDR);
  assign wr_tifr   = wr && (addr == TIFR4_ADDR);
  assign rd_tcnt   = rd && (addr == TCNT4_ADDR);

  assign clr_strobe = wr_tccr4a & bus_in[1];
  assign stopped    = (cs4 == 4'd0);
  assign wdata10    = {tc4h, bus_in};

  // CS4 = n ticks when the low n-1 prescaler bits are all ones; 14-bit wrap makes n = 15 all ones.
  assign ps_mask  = (14'd1 << (cs4 - 4'd1)) - 14'd1;
  assign tick     = tim_ck_en && !stopped && ((prescaler & ps_mask) == ps_mask);
  assign tick_eff = tick && !wr_tcnt && !clr_strobe;
  assign at_top   = (tcnt4 == ocr4c_act) || (tcnt4 == 10'h3FF);
  assign wrap     = tick_eff && at_top;
  assign match    = tick_eff && (tcnt4 == ocr4a_act);

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm4a     <= 1'b0;
      cs4       <= 4'd0;
      tc4h      <= 2'd0;
      tcnt4     <= 10'd0;
      ocr4a_buf <= 10'd0;
      ocr4a_act <= 10'd0;
      ocr4c_buf <= 10'h3FF;
      ocr4c_act <= 10'h3FF;
      toie4     <= 1'b0;
      ocie4a    <= 1'b0;
      tov4      <= 1'b0;
      ocf4a     <= 1'b0;
      prescaler <= 14'd0;
      oc4a_pwm  <= 1'b0;
    end else begin
      if (wr_tccr4a) pwm4a <= bus_in[0];
      if (wr_tccr4b) cs4 <= bus_in[3:0];
      if (wr_timsk) begin
        toie4  <= bus_in[0];
        ocie4a <= bus_in[1];
      end

      if (wr_tc4h)      tc4h <= bus_in[1:0];
      else if (rd_tcnt) tc4h <= tcnt4[9:8];

      if (wr_tccr4b || clr_strobe)     prescaler <= 14'd0;
      else if (tim_ck_en && !stopped)  prescaler <= prescaler + 14'd1;

      if (clr_strobe)   tcnt4 <= 10'd0;
      else if (wr_tcnt) tcnt4 <= wdata10;
      else if (wrap)    tcnt4 <= 10'd0;
      else if (tick_eff) tcnt4 <= tcnt4 + 10'd1;

      // Compare values are double-buffered; a stopped timer takes writes straight through.
      if (wr_ocra) ocr4a_buf <= wdata10;
      if (wr_ocra && stopped) ocr4a_act <= wdata10;
      else if (wrap)          ocr4a_act <= ocr4a_buf;

      if (wr_ocrc) ocr4c_buf <= wdata10;
      if (wr_ocrc && stopped) ocr4c_act <= wdata10;
      else if (wrap)          ocr4c_act <= ocr4c_buf;

      tov4  <= wrap  | (tov4  & ~(wr_tifr & bus_in[0]) & ~tov_int_rst);
      ocf4a <= match | (ocf4a & ~(wr_tifr & bus_in[1]) & ~oca_int_rst);

      if (!pwm4a)    oc4a_pwm <= 1'b0;
      else if (match) oc4a_pwm <= 1'b0;
      else if (wrap)  oc4a_pwm <= 1'b1;
    end
  end

  assign tov_int = tov4 & toie4;
  assign oca_int = ocf4a & ocie4a;

`ifdef ATMEGA_TIM4_DEAD_TIME_EN
  logic [7:0] dt4;
  logic [3:0] dt_cnt_a, dt_cnt_n;
  logic       pwm_n;

  assign pwm_n = pwm4a & ~oc4a_pwm;

  // Each counter reloads while its source is low, so a rising edge waits out the full dead time.
  always_ff @(posedge clk) begin
    if (rst) begin
      dt4      <= 8'h00;
      dt_cnt_a <= 4'd0;
      dt_cnt_n <= 4'd0;
    end else begin
      if (wr && (addr == DT4_ADDR)) dt4 <= bus_in;
      if (!oc4a_pwm)             dt_cnt_a <= dt4[7:4];
      else if (dt_cnt_a != 4'd0) dt_cnt_a <= dt_cnt_a - 4'd1;
      if (!pwm_n)                dt_cnt_n <= dt4[3:0];
      else if (dt_cnt_n != 4'd0) dt_cnt_n <= dt_cnt_n - 4'd1;
    end
  end

  assign oc4a   = oc4a_pwm & (dt_cnt_a == 4'd0);
  assign oc4a_n = pwm_n & (dt_cnt_n == 4'd0);
  assign dt4_rd = dt4;
`else
  assign oc4a   = oc4a_pwm;
  assign oc4a_n = 1'b0;
  assign dt4_rd = 8'h00;
`endif

  always_comb begin
    bus_out = 8'h00;
    if (rd) begin
      case (addr)
        TCCR4A_ADDR: bus_out = {7'd0, pwm4a};
        TCCR4B_ADDR: bus_out = {4'd0, cs4};
        TC4H_ADDR:   bus_out = {6'd0, tc4h};
        TCNT4_ADDR:  bus_out = tcnt4[7:0];
        OCR4A_ADDR:  bus_out = ocr4a_buf[7:0];
        OCR4C_ADDR:  bus_out = ocr4c_buf[7:0];
        TIMSK4_ADDR: bus_out = {6'd0, ocie4a, toie4};
        TIFR4_ADDR:  bus_out = {6'd0, ocf4a, tov4};
        DT4_ADDR:    bus_out = dt4_rd;
        default:     bus_out = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_atmega_tim4_hs.sv
// Directed bench for atmega_tim4_hs: expected values queued at stimulus time, popped at each check.
module tb_atmega_tim4_hs;

  localparam logic [5:0] A_TCCR4A = 6'h20;
  localparam logic [5:0] A_TCCR4B = 6'h21;
  localparam logic [5:0] A_TC4H   = 6'h22;
  localparam logic [5:0] A_TCNT4  = 6'h23;
  localparam logic [5:0] A_OCR4A  = 6'h24;
  localparam logic [5:0] A_OCR4C  = 6'h25;
  localparam logic [5:0] A_TIMSK4 = 6'h26;
  localparam logic [5:0] A_TIFR4  = 6'h27;
  localparam logic [5:0] A_DT4    = 6'h28;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] addr;
  logic       wr, rd;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       tim_ck_en;
  logic       tov_int_rst, oca_int_rst;
  logic       tov_int, oca_int, oc4a, oc4a_n;

  int    n_tests = 0;
  int    n_fail  = 0;
  int    en_mode = 0;
  string tag_q[$];
  int    exp_q[$];

  atmega_tim4_hs dut (
    .rst(rst), .clk(clk), .addr(addr), .wr(wr), .rd(rd),
    .bus_in(bus_in), .bus_out(bus_out), .tim_ck_en(tim_ck_en),
    .tov_int_rst(tov_int_rst), .oca_int_rst(oca_int_rst),
    .tov_int(tov_int), .oca_int(oca_int), .oc4a(oc4a), .oc4a_n(oc4a_n)
  );

  always #5 clk = ~clk;

  initial begin
    tim_ck_en = 1'b1;
    forever begin
      @(negedge clk);
      tim_ck_en = (en_mode == 0) ? 1'b1 : ~tim_ck_en;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string t, input int v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input int obs);
    string t;
    int e;
    t = "queue_empty";
    e = -1;
    if (exp_q.size() > 0) begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
    end
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", t, obs, e);
    end
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [7:0] d);
    addr = a; bus_in = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [5:0] a, output logic [7:0] d);
    addr = a; rd = 1'b1;
    #1 d = bus_out;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic rd_chk(input string t, input logic [5:0] a, input int e);
    logic [7:0] d;
    push(t, e);
    bus_read(a, d);
    check(int'(d));
  endtask

  function automatic logic sig(input bit sel);
    return sel ? oc4a_n : oc4a;
  endfunction

  // Returns at the first negedge where the selected output is seen high after being low.
  task automatic wait_rise(input bit sel);
    int c = 0;
    while (sig(sel) && c < 100) begin @(negedge clk); c++; end
    while (!sig(sel) && c < 100) begin @(negedge clk); c++; end
    n_tests++;
    assert (c < 100) else begin
      n_fail++;
      $error("FAIL wait_rise: observed %0d cycles required under 100", c);
    end
  endtask

  task automatic measure(input bit sel, input bit level, output int n);
    n = 0;
    while ((sig(sel) == level) && n < 100) begin n++; @(negedge clk); end
  endtask

  initial begin
    logic [7:0] d;
    int n, c, both;
    int rst_exp[9] = '{0, 0, 0, 0, 0, 'hFF, 0, 0, 0};

    rst = 1'b1; wr = 1'b0; rd = 1'b0; addr = '0; bus_in = '0;
    tov_int_rst = 1'b0; oca_int_rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    push("rst_oc4a", 0);    check(int'(oc4a));
    push("rst_oc4a_n", 0);  check(int'(oc4a_n));
    push("rst_tov_int", 0); check(int'(tov_int));
    push("rst_oca_int", 0); check(int'(oca_int));
    for (int i = 0; i < 9; i++) rd_chk($sformatf("rst_reg_%0h", 6'h20 + i), A_TCCR4A + 6'(i), rst_exp[i]);

    // 256 ticks from 0x010 with CS4 = 1
    bus_write(A_TCNT4, 8'h10);
    bus_write(A_TCCR4B, 8'h01);
    repeat (255) @(negedge clk);
    bus_write(A_TCCR4B, 8'h00);
    rd_chk("tcnt_lo", A_TCNT4, 'h10);
    rd_chk("tc4h_latched", A_TC4H, 'h01);
    repeat (10) @(negedge clk);
    rd_chk("tcnt_frozen", A_TCNT4, 'h10);
    rd_chk("tifr_no_wrap", A_TIFR4, 'h00);

    // CLR strobe
    bus_write(A_TCCR4A, 8'h02);
    rd_chk("clr_tcnt", A_TCNT4, 'h00);
    rd_chk("clr_self_clears", A_TCCR4A, 'h00);

    // Fast PWM, TOP = 9, compare = 3
    bus_write(A_OCR4C, 8'h09);
    bus_write(A_OCR4A, 8'h03);
    bus_write(A_TIMSK4, 8'h01);
    bus_write(A_TCCR4A, 8'h01);
    bus_write(A_TCCR4B, 8'h01);
    wait_rise(0);
    push("pwm_high", 4); measure(0, 1, n); check(n);
    push("pwm_low", 6);  measure(0, 0, n); check(n);

    wait_rise(0);
    push("tov_int_set", 1); check(int'(tov_int));
    tov_int_rst = 1'b1;
    @(negedge clk);
    tov_int_rst = 1'b0;
    c = 1;
    push("tov_int_cleared", 0); check(int'(tov_int));
    while (!tov_int && c < 50) begin @(negedge clk); c++; end
    push("tov_period", 10); check(c);
    push("oca_int_masked", 0); check(int'(oca_int));
    bus_write(A_TIMSK4, 8'h03);
    push("oca_int_on", 1); check(int'(oca_int));

    bus_write(A_TCCR4B, 8'h00);
    oca_int_rst = 1'b1;
    @(negedge clk);
    oca_int_rst = 1'b0;
    push("oca_int_ack", 0); check(int'(oca_int));
    bus_write(A_TIFR4, 8'h02);
    rd_chk("tifr_zero_no_effect", A_TIFR4, 'h01);
    bus_write(A_TIFR4, 8'h01);
    rd_chk("tifr_w1c", A_TIFR4, 'h00);

    // CS4 = 3 with tim_ck_en every other clk: 64 clks -> 8 ticks
    en_mode = 1;
    bus_write(A_TCCR4A, 8'h03);
    repeat (4) @(negedge clk);
    bus_write(A_TCCR4B, 8'h03);
    repeat (63) @(negedge clk);
    bus_write(A_TCCR4B, 8'h00);
    rd_chk("presc_cs3", A_TCNT4, 8);
    repeat (20) @(negedge clk);
    rd_chk("presc_frozen", A_TCNT4, 8);
    en_mode = 0;
    repeat (2) @(negedge clk);

    // Buffered OCR4A update takes effect at the next wrap
    bus_write(A_TCCR4B, 8'h01);
    wait_rise(0);
    bus_write(A_OCR4A, 8'h07);
    measure(0, 1, n);
    push("ocr_buf_old_duty", 4); check(n + 1);
    wait_rise(0);
    push("ocr_buf_new_duty", 8); measure(0, 1, n); check(n);

    bus_write(A_TCNT4, 8'h05);
    rd_chk("tcnt_wr_wins", A_TCNT4, 'h05);

    bus_write(A_TCCR4A, 8'h00);
    @(negedge clk);
    push("pwm_off", 0); check(int'(oc4a));

    // Counter above TOP runs to 0x3FF then wraps with TOV4
    bus_write(A_TCCR4B, 8'h00);
    bus_write(A_TIFR4, 8'h03);
    bus_write(A_TC4H, 8'h03);
    bus_write(A_TCNT4, 8'hF0);
    rd_chk("tifr_cleared", A_TIFR4, 'h00);
    bus_write(A_TCCR4B, 8'h01);
    repeat (14) @(negedge clk);
    bus_write(A_TCCR4B, 8'h00);
    rd_chk("tcnt_3ff_lo", A_TCNT4, 'hFF);
    rd_chk("tcnt_3ff_hi", A_TC4H, 'h03);
    rd_chk("no_tov_at_3ff", A_TIFR4, 'h00);
    bus_write(A_TCCR4B, 8'h01);
    bus_write(A_TCCR4B, 8'h00);
    rd_chk("wrap_3ff_tcnt", A_TCNT4, 'h00);
    rd_chk("wrap_3ff_tov", A_TIFR4, 'h01);

`ifdef ATMEGA_TIM4_DEAD_TIME_EN
    bus_write(A_DT4, 8'h21);
    rd_chk("dt4_rw", A_DT4, 'h21);
    bus_write(A_OCR4A, 8'h04);
    bus_write(A_TCCR4A, 8'h01);
    bus_write(A_TCCR4B, 8'h01);
    both = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (oc4a && oc4a_n) both++;
    end
    push("dt_no_overlap", 0); check(both);
    wait_rise(0);
    push("dt_oc4a_high", 3); measure(0, 1, n); check(n);
    wait_rise(1);
    push("dt_oc4a_n_high", 4); measure(1, 1, n); check(n);
`else
    bus_write(A_DT4, 8'h21);
    rd_chk("dt4_absent", A_DT4, 'h00);
    bus_write(A_TCCR4A, 8'h01);
    bus_write(A_TCCR4B, 8'h01);
    both = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (oc4a_n) both++;
    end
    push("oc4a_n_absent", 0); check(both);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
